// File: rtl/rank_decoder.sv
// Rank-order AER decoder: the Nth distinct pixel event gets intensity PIXEL_MAX_VALUE-N.
// Optional macro RANK_DEC_REQ_SYNC_EN adds a two-flop synchronizer on AERIN_REQ.
`timescale 1ns/1ps

// state    | meaning
// IDLE     | waiting for NEW_IMAGE; image held
// WAIT_REQ | waiting for an AER request, captures address
// WRITE    | writes the pixel or flags a discarded event
// ACK      | acknowledge asserted until request drops
// CHECK    | decides whether all pixels have been ranked
// DONE     | one-cycle completion pulse
module rank_decoder #(
  parameter int IMAGE_SIZE      = 5,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int PIXEL_MAX_VALUE = 10,
  parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE)
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    NEW_IMAGE,
  input  logic                    AERIN_REQ,
  input  logic [IMAGE_SIZE_BITS:0] AERIN_ADDR,
  output logic                    AERIN_ACK,
  output logic [PIXEL_BITS:0]     IMAGE [0:IMAGE_SIZE-1],
  output logic                    BUSY,
  output logic                    IMAGE_DECODED,
  output logic                    DECODE_ERR
);

  localparam int RW  = IMAGE_SIZE_BITS + 1;
  localparam int PW  = PIXEL_BITS + 1;
  localparam int CWP = ((RW > PW) ? RW : PW) + 1;
  localparam logic [RW-1:0]  SIZE_L = RW'(IMAGE_SIZE);
  localparam logic [CWP-1:0] MAX_L  = CWP'(PIXEL_MAX_VALUE);

  typedef enum logic [2:0] {IDLE, WAIT_REQ, WRITE, ACK, CHECK, DONE} state_t;

  state_t                state;
  logic [RW-1:0]         rank;
  logic [RW-1:0]         addr_q;
  logic [IMAGE_SIZE-1:0] mask;
  logic [IMAGE_SIZE-1:0] hit;
  logic                  write_ok;
  logic [PW-1:0]         pix_val;
  logic                  req_s;

`ifdef RANK_DEC_REQ_SYNC_EN
  logic [1:0] req_sync;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) req_sync <= '0;
    else        req_sync <= {req_sync[0], AERIN_REQ};
  end
  assign req_s = req_sync[1];
`else
  assign req_s = AERIN_REQ;
`endif

  // One-hot decode of the captured address; empty when out of range.
  always_comb begin
    hit = '0;
    for (int i = 0; i < IMAGE_SIZE; i++) hit[i] = (addr_q == RW'(i));
  end

  assign write_ok = (|hit) && !(|(hit & mask));

  always_comb begin
    pix_val = '0;
    if (CWP'(rank) <= MAX_L) pix_val = PW'(MAX_L - CWP'(rank));
  end

  assign BUSY          = (state != IDLE);
  assign IMAGE_DECODED = (state == DONE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      rank       <= '0;
      mask       <= '0;
      addr_q     <= '0;
      AERIN_ACK  <= 1'b0;
      DECODE_ERR <= 1'b0;
      for (int i = 0; i < IMAGE_SIZE; i++) IMAGE[i] <= '0;
    end else begin
      // Registered one cycle behind the state so ACK rises two cycles after req is seen.
      AERIN_ACK <= (state == ACK);
      case (state)
        IDLE: begin
          if (NEW_IMAGE) begin
            for (int i = 0; i < IMAGE_SIZE; i++) IMAGE[i] <= '0;
            rank       <= '0;
            mask       <= '0;
            DECODE_ERR <= 1'b0;
            state      <= WAIT_REQ;
          end
        end
        WAIT_REQ: begin
          if (req_s) begin
            addr_q <= AERIN_ADDR;
            state  <= WRITE;
          end
        end
        WRITE: begin
          if (write_ok) begin
            for (int i = 0; i < IMAGE_SIZE; i++)
              if (hit[i]) IMAGE[i] <= pix_val;
            mask <= mask | hit;
            rank <= rank + RW'(1);
          end else begin
            DECODE_ERR <= 1'b1;
          end
          state <= ACK;
        end
        ACK: begin
          if (!req_s) state <= CHECK;
        end
        CHECK: begin
          state <= (rank == SIZE_L) ? DONE : WAIT_REQ;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rank_decoder.sv
// Scoreboard bench for rank_decoder: expected images are queued when a decode is
// issued and a monitor compares them against IMAGE on every IMAGE_DECODED pulse.
`timescale 1ns/1ps

module tb_rank_decoder;

  localparam int N    = 5;
  localparam int MAXV = 10;
  localparam int AW   = 4;
  localparam int PW   = 5;
`ifdef RANK_DEC_REQ_SYNC_EN
  localparam int RISE_LAT = 5;
  localparam int FALL_LAT = 4;
`else
  localparam int RISE_LAT = 3;
  localparam int FALL_LAT = 2;
`endif

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          NEW_IMAGE = 1'b0;
  logic          AERIN_REQ = 1'b0;
  logic [AW-1:0] AERIN_ADDR = '0;
  logic          AERIN_ACK;
  logic [PW-1:0] IMAGE [0:N-1];
  logic          BUSY;
  logic          IMAGE_DECODED;
  logic          DECODE_ERR;

  rank_decoder #(.IMAGE_SIZE(N), .PIXEL_MAX_VALUE(MAXV)) dut (
    .CLK(CLK), .RST_N(RST_N), .NEW_IMAGE(NEW_IMAGE), .AERIN_REQ(AERIN_REQ),
    .AERIN_ADDR(AERIN_ADDR), .AERIN_ACK(AERIN_ACK), .IMAGE(IMAGE), .BUSY(BUSY),
    .IMAGE_DECODED(IMAGE_DECODED), .DECODE_ERR(DECODE_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [N-1:0][PW-1:0] img;
    logic                 err;
  } exp_t;

  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: rank order of distinct in-range pixel events.
  int m_img [N];
  bit m_done_mask [N];
  int m_rank;
  bit m_err;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  task automatic m_start();
    for (int i = 0; i < N; i++) begin m_img[i] = 0; m_done_mask[i] = 0; end
    m_rank = 0;
    m_err  = 0;
  endtask

  task automatic m_push();
    exp_t e;
    for (int i = 0; i < N; i++) e.img[i] = PW'(m_img[i]);
    e.err = m_err;
    exp_q.push_back(e);
  endtask

  task automatic m_event(input int addr);
    if (addr < N && !m_done_mask[addr]) begin
      m_img[addr] = (m_rank > MAXV) ? 0 : MAXV - m_rank;
      m_done_mask[addr] = 1;
      m_rank++;
      if (m_rank == N) m_push();
    end else begin
      m_err = 1;
    end
  endtask

  task automatic push_lit(input int p0, input int p1, input int p2, input int p3,
                          input int p4, input bit err);
    exp_t e;
    e.img[0] = PW'(p0); e.img[1] = PW'(p1); e.img[2] = PW'(p2);
    e.img[3] = PW'(p3); e.img[4] = PW'(p4);
    e.err = err;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per completion pulse.
  always @(negedge CLK) begin
    if (IMAGE_DECODED) begin
      if (exp_q.size() == 0) begin
        timeout_fail("unexpected_image_decoded_pulse");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        for (int i = 0; i < N; i++)
          check($sformatf("decoded_img[%0d]", i), int'(IMAGE[i]), int'(e.img[i]));
        check("decoded_err", int'(DECODE_ERR), int'(e.err));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_image();
    tick();
    NEW_IMAGE = 1'b1;
    tick();
    NEW_IMAGE = 1'b0;
  endtask

  task automatic send_event(input int addr);
    int n;
    tick();
    AERIN_ADDR = AW'(addr);
    AERIN_REQ  = 1'b1;
    n = 0;
    while (!AERIN_ACK && n < 50) begin tick(); n++; end
    if (!AERIN_ACK) timeout_fail("ack_rise");
    AERIN_REQ = 1'b0;
    n = 0;
    while (AERIN_ACK && n < 50) begin tick(); n++; end
    if (AERIN_ACK) timeout_fail("ack_fall");
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (BUSY && n < 100) begin tick(); n++; end
    if (BUSY) timeout_fail("wait_idle");
  endtask

  task automatic check_all_zero(input string name);
    int nz;
    nz = 0;
    for (int i = 0; i < N; i++) if (IMAGE[i] != '0) nz++;
    check(name, nz, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise_at, fall_at, high_cnt, guard, a;

    // Reset state
    #12;
    check("rst_busy", int'(BUSY), 0);
    check("rst_ack", int'(AERIN_ACK), 0);
    check("rst_decoded", int'(IMAGE_DECODED), 0);
    check("rst_err", int'(DECODE_ERR), 0);
    check_all_zero("rst_image_zero");
    tick();
    RST_N = 1'b1;
    repeat (2) tick();

    // Permutation 3,0,4,1,2
    start_image();
    check("busy_after_new_image", int'(BUSY), 1);
    push_lit(9, 7, 6, 10, 8, 1'b0);
    send_event(3); send_event(0); send_event(4); send_event(1); send_event(2);
    wait_idle();

    // Duplicate event is acked and discarded
    start_image();
    push_lit(9, 8, 10, 7, 6, 1'b1);
    send_event(2); send_event(2); send_event(0); send_event(1); send_event(3);
    repeat (3) tick();
    check("dup_busy_before_6th", int'(BUSY), 1);
    check("dup_err_sticky", int'(DECODE_ERR), 1);
    send_event(4);
    wait_idle();

    // Out-of-range address
    start_image();
    send_event(7);
    repeat (3) tick();
    check("oor_err", int'(DECODE_ERR), 1);
    check("oor_busy", int'(BUSY), 1);
    check_all_zero("oor_image_zero");
    push_lit(10, 9, 8, 7, 6, 1'b1);
    for (int i = 0; i < N; i++) send_event(i);
    wait_idle();

    // Long request: ack latencies and a single write
    start_image();
    push_lit(9, 8, 10, 7, 6, 1'b0);
    tick();
    AERIN_ADDR = AW'(2);
    AERIN_REQ  = 1'b1;
    rise_at = -1;
    high_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (AERIN_ACK) begin
        high_cnt++;
        if (rise_at < 0) rise_at = k;
      end
    end
    check("ack_rise_latency", rise_at, RISE_LAT);
    check("ack_held_cycles", high_cnt, 10 - RISE_LAT + 1);
    AERIN_REQ = 1'b0;
    fall_at = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (!AERIN_ACK && fall_at < 0) fall_at = k;
    end
    check("ack_fall_latency", fall_at, FALL_LAT);
    send_event(0); send_event(1); send_event(3); send_event(4);
    wait_idle();

    // Reset while in ACK with req high
    start_image();
    send_event(0); send_event(1); send_event(2);
    tick();
    AERIN_ADDR = AW'(3);
    AERIN_REQ  = 1'b1;
    guard = 0;
    while (!AERIN_ACK && guard < 50) begin tick(); guard++; end
    if (!AERIN_ACK) timeout_fail("rst_ack_rise");
    #2 RST_N = 1'b0;
    #1;
    check("abort_ack", int'(AERIN_ACK), 0);
    check("abort_busy", int'(BUSY), 0);
    check("abort_decoded", int'(IMAGE_DECODED), 0);
    check("abort_err", int'(DECODE_ERR), 0);
    check_all_zero("abort_image_zero");
    tick();
    AERIN_REQ = 1'b0;
    tick();
    #2 RST_N = 1'b1;
    repeat (5) tick();
    check("abort_stays_idle", int'(BUSY), 0);
    start_image();
    push_lit(6, 7, 8, 9, 10, 1'b0);
    for (int i = N - 1; i >= 0; i--) send_event(i);
    wait_idle();

    // NEW_IMAGE while busy is ignored
    start_image();
    push_lit(9, 10, 8, 7, 6, 1'b0);
    send_event(1); send_event(0);
    tick();
    NEW_IMAGE = 1'b1;
    tick();
    NEW_IMAGE = 1'b0;
    repeat (2) tick();
    check("busy_newimg_px1", int'(IMAGE[1]), 10);
    check("busy_newimg_px0", int'(IMAGE[0]), 9);
    check("busy_newimg_busy", int'(BUSY), 1);
    send_event(2); send_event(3); send_event(4);
    wait_idle();

    // Randomized decodes against the reference model
    for (int img = 0; img < 15; img++) begin
      m_start();
      start_image();
      check_all_zero("rand_clear_image");
      check("rand_clear_err", int'(DECODE_ERR), 0);
      guard = 0;
      while (m_rank < N && guard < 80) begin
        if ($urandom_range(0, 9) < 8) a = int'($urandom_range(0, N - 1));
        else                          a = int'($urandom_range(0, (1 << AW) - 1));
        m_event(a);
        send_event(a);
        guard++;
      end
      wait_idle();
      repeat (3) tick();
      for (int i = 0; i < N; i++)
        check($sformatf("rand_hold_img[%0d]", i), int'(IMAGE[i]), m_img[i]);
      check("rand_hold_decoded_low", int'(IMAGE_DECODED), 0);
    end

    repeat (4) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rank_decoder.md
RANK_DECODER -- requirements
Module: rank_decoder

Interface
REQ-001 The module SHALL take parameter IMAGE_SIZE, default 5, meaning number of pixels per image.
REQ-002 The module SHALL take parameter IMAGE_SIZE_BITS, default $clog2(IMAGE_SIZE), meaning pixel index width minus one.
REQ-003 The module SHALL take parameter PIXEL_MAX_VALUE, default 10, meaning intensity assigned to rank 0.
REQ-004 The module SHALL take parameter PIXEL_BITS, default $clog2(PIXEL_MAX_VALUE), meaning pixel value width minus one.
REQ-005 Ports SHALL be:
  CLK  in  1  the single clock, rising edge.
  RST_N  in  1  asynchronous, active-low reset.
  NEW_IMAGE  in  1  single-cycle start of a decode.
  AERIN_REQ  in  1  4-phase AER request.
  AERIN_ADDR  in  IMAGE_SIZE_BITS+1  pixel index carried by the event; stable while AERIN_REQ is high.
  AERIN_ACK  out  1  4-phase AER acknowledge.
  IMAGE  out  array [0:IMAGE_SIZE-1] of PIXEL_BITS+1  reconstructed image.
  BUSY  out  1  high in every state except IDLE.
  IMAGE_DECODED  out  1  single-cycle pulse on completion.
  DECODE_ERR  out  1  sticky flag for a discarded event.

Function
REQ-006 The FSM SHALL have states IDLE, WAIT_REQ, WRITE, ACK, CHECK and DONE.
REQ-007 In IDLE, NEW_IMAGE=1 SHALL clear IMAGE to 0, rank counter to 0, written-mask to 0 and DECODE_ERR to 0, then go to WAIT_REQ.
REQ-008 In any state other than IDLE, NEW_IMAGE SHALL be ignored.
REQ-009 In WAIT_REQ, a sampled req=1 SHALL capture AERIN_ADDR into an internal register and go to WRITE; otherwise the FSM SHALL stay in WAIT_REQ.
REQ-010 In WRITE, when addr<IMAGE_SIZE and the written-mask bit is 0, the block SHALL:
  - set IMAGE[addr] to PIXEL_MAX_VALUE-rank, saturating at 0 when rank>PIXEL_MAX_VALUE;
  - set the mask bit;
  - increment rank.
REQ-011 In WRITE, an out-of-range addr or an already-written addr SHALL leave IMAGE and rank unchanged and SHALL set DECODE_ERR; the FSM SHALL then go to ACK.
REQ-012 AERIN_ACK SHALL be high only in ACK; the FSM SHALL leave ACK for CHECK on the first cycle where sampled req=0.
REQ-013 In CHECK, rank==IMAGE_SIZE SHALL go to DONE; otherwise the FSM SHALL go to WAIT_REQ.
REQ-014 In DONE, IMAGE_DECODED SHALL be 1 for exactly one cycle and the FSM SHALL then go to IDLE.
REQ-015 IMAGE SHALL hold its value after DONE until the next accepted NEW_IMAGE.
REQ-016 Without synchronizer, AERIN_ACK SHALL rise 2 cycles after the edge at which req is first seen high, and SHALL fall 1 cycle after req is seen low.
REQ-017 The rank counter SHALL be IMAGE_SIZE_BITS+1 bits wide and SHALL never exceed IMAGE_SIZE.
REQ-018 All outputs SHALL be registered or decoded from the state register only, with no combinational path from inputs.

Reset
REQ-019 On RST_N=0, asynchronously: state SHALL be IDLE, IMAGE all 0, rank 0, mask 0, captured addr 0, AERIN_ACK 0, BUSY 0, IMAGE_DECODED 0, DECODE_ERR 0.
REQ-020 A reset during any state, including ACK with req high, SHALL abort the decode with no IMAGE_DECODED pulse.
REQ-021 After reset release, the block SHALL wait for a new NEW_IMAGE.

Configuration
REQ-022 With macro RANK_DEC_REQ_SYNC_EN defined, AERIN_REQ SHALL pass through a two-flop synchronizer (reset to 0) before FSM use, and REQ-016 latencies SHALL each increase by 2 cycles.
REQ-023 With RANK_DEC_REQ_SYNC_EN undefined, AERIN_REQ SHALL be sampled directly, and AERIN_ADDR SHALL be captured in the same cycle req is sampled in both builds.

Verification (IMAGE_SIZE=5, PIXEL_MAX_VALUE=10)
REQ-024 NEW_IMAGE, then events 3,0,4,1,2 -> IMAGE={9,7,6,10,8}, one IMAGE_DECODED pulse, DECODE_ERR=0.
REQ-025 Events 2,2,0,1,3,4 -> second 2 acknowledged and discarded, DECODE_ERR=1, IMAGE={9,8,10,7,6}, decode completes after the 6th event.
REQ-026 Event addr=7 -> acknowledged, DECODE_ERR=1, rank stays 0, IMAGE all 0, BUSY stays 1.
REQ-027 Req held high 10 cycles -> AERIN_ACK held high for those cycles, a single write occurs, and ACK drops 1 cycle after req falls (3 cycles with RANK_DEC_REQ_SYNC_EN).
REQ-028 RST_N pulsed low in ACK after 3 events -> all outputs 0, no IMAGE_DECODED pulse, and a following NEW_IMAGE plus 5 events decodes correctly.
REQ-029 NEW_IMAGE pulsed while BUSY=1 -> ignored, and IMAGE already written is not cleared.
